// File: rtl/serial_adder_ctrl.sv
// Bit-serial unsigned adder: one full adder reused LSB-first, WIDTH RUN cycles per add.
// done pulses the cycle after the last RUN edge; start is ignored while busy.

module halfadder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_s1;
    logic             w_c1;
    logic             w_s;
    logic             w_c2;
    logic             w_cout;

    halfadder u_ha0 (.i_a(r_a[0]), .i_b(r_b[0]), .o_s(w_s1), .o_c(w_c1));
    halfadder u_ha1 (.i_a(w_s1),   .i_b(r_c),    .o_s(w_s),  .o_c(w_c2));
    assign w_cout = w_c1 | w_c2;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_c is the working carry cleared on accept; r_carry holds the visible result
    // until the next operation's first RUN edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_c     <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a   <= inA;
            r_b   <= inB;
            r_c   <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_c     <= w_cout;
            r_carry <= w_cout;
            if (!w_last) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign ready = (r_state == S_IDLE) || (r_state == S_DONE);
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign sum   = r_sum;
    assign carry = r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed checks of serial_adder_ctrl (WIDTH=8 and WIDTH=4) against plain arithmetic.
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start4;
    logic [7:0] inA8, inB8, sum8;
    logic [3:0] inA4, inB4, sum4;
    logic       ready8, busy8, done8, carry8;
    logic       ready4, busy4, done4, carry4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .inA(inA8), .inB(inB8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .inA(inA4), .inB(inB4),
        .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance edge by edge (sampling #1 after each) until done8; e0 is the number
    // of edges already elapsed since the accepting edge.
    task automatic wait_done8(input int e0, output int lat, output int nbusy);
        lat   = -1;
        nbusy = 0;
        for (int i = e0 + 1; i <= e0 + 24; i++) begin
            if (busy8) nbusy++;
            @(posedge clk); #1;
            if (done8) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) chk("done8_timeout", 32'd0, 32'd1);
    endtask

    // Reference: result is simply a+b with its 9th bit as carry, after exactly 8 RUN edges.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] exp;
        int lat, nb;
        exp = {1'b0, a} + {1'b0, b};
        @(negedge clk);
        start8 = 1'b1; inA8 = a; inB8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8(0, lat, nb);
        chk({tag, "_lat"},   lat, 8);
        chk({tag, "_busy"},  nb, 8);
        chk({tag, "_sum"},   sum8, exp[7:0]);
        chk({tag, "_carry"}, carry8, exp[8]);
        @(posedge clk); #1;
        chk({tag, "_done_1cyc"}, done8, 1'b0);
        chk({tag, "_hold_sum"},  sum8, exp[7:0]);
    endtask

    initial begin
        int lat, nb, ndone;
        logic [8:0] e;
        logic [4:0] e4;
        rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
        inA8 = '0; inB8 = '0; inA4 = '0; inB4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready8, 1'b1);
        chk("rst_busy",  busy8,  1'b0);
        chk("rst_done",  done8,  1'b0);
        chk("rst_sum",   sum8,   8'h00);
        chk("rst_carry", carry8, 1'b0);
        rst_n = 1'b1;

        run8("5a_33", 8'h5A, 8'h33);
        chk("5a_33_value", sum8, 8'h8D);
        run8("ff_01", 8'hFF, 8'h01);
        run8("ff_ff", 8'hFF, 8'hFF);
        run8("00_00", 8'h00, 8'h00);

        // Start with other operands during RUN edge 3 must be ignored.
        @(negedge clk);
        start8 = 1'b1; inA8 = 8'h5A; inB8 = 8'h33;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start8 = 1'b1; inA8 = 8'hC3; inB8 = 8'h77;
        @(posedge clk); #1;
        start8 = 1'b0; inA8 = 8'h00; inB8 = 8'h00;
        wait_done8(3, lat, nb);
        chk("ign_lat",   lat, 8);
        chk("ign_sum",   sum8, 8'h8D);
        chk("ign_carry", carry8, 1'b0);

        // Reset asserted at RUN edge 4 abandons the operation.
        @(negedge clk);
        start8 = 1'b1; inA8 = 8'h5A; inB8 = 8'h33;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst4_busy",  busy8,  1'b0);
        chk("rst4_ready", ready8, 1'b1);
        chk("rst4_sum",   sum8,   8'h00);
        chk("rst4_carry", carry8, 1'b0);
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        chk("rst4_no_done", ndone, 0);

        // start held high through DONE chains a second operation.
        @(negedge clk);
        start8 = 1'b1; inA8 = 8'h01; inB8 = 8'h02;
        @(posedge clk); #1;
        inA8 = 8'h80; inB8 = 8'h80;
        wait_done8(0, lat, nb);
        chk("hold1_lat",   lat, 8);
        chk("hold1_sum",   sum8, 8'h03);
        chk("hold1_carry", carry8, 1'b0);
        wait_done8(lat, lat, nb);
        start8 = 1'b0;
        chk("hold2_lat",   lat, 17);
        chk("hold2_sum",   sum8, 8'h00);
        chk("hold2_carry", carry8, 1'b1);

        for (int k = 0; k < 24; k++) begin
            run8("rnd", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                e4 = 5'(a + b);
                @(negedge clk);
                start4 = 1'b1; inA4 = 4'(a); inB4 = 4'(b);
                @(posedge clk); #1;
                start4 = 1'b0;
                lat = -1;
                for (int i = 1; i <= 10; i++) begin
                    @(posedge clk); #1;
                    if (done4) begin
                        lat = i;
                        break;
                    end
                end
                chk("w4_lat", lat, 4);
                chk("w4_result", {carry4, sum4}, e4);
            end
        end

        e = 9'h0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand and result width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to add inA+inB; sampled on rising edge.
REQ-005 inA  input  WIDTH  operand A; sampled only on an accepted start.
REQ-006 inB  input  WIDTH  operand B; sampled only on an accepted start.
REQ-007 ready  output  1  high when a start will be accepted (state IDLE or DONE).
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  WIDTH  result bits, LSB first assembled.
REQ-011 carry  output  1  carry-out of bit WIDTH-1.

Function
REQ-012 The datapath SHALL be one 1-bit full adder built from two Halfadder instances plus an OR of their carries, reused once per bit, LSB first.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-014 IDLE or DONE with start=1 at an edge SHALL: load shift regs A<=inA, B<=inB, clear carry flop, clear bit counter to 0, go to RUN.
REQ-015 IDLE with start=0 SHALL stay IDLE; DONE with start=0 SHALL go to IDLE after one cycle.
REQ-016 Each RUN edge SHALL compute s=A[0]^B[0]^c, c'=majority(A[0],B[0],c), shift A and B right by 1, shift s into the sum register MSB (sum shifts right), store c' in the carry flop, increment counter.
REQ-017 On the RUN edge where counter equals WIDTH-1, FSM SHALL go to DONE; exactly WIDTH RUN edges per operation.
REQ-018 done SHALL be high exactly while state is DONE (one cycle unless a new start is accepted, which still leaves only one cycle).
REQ-019 Latency: with start accepted at edge E0, done SHALL be high in the cycle after edge E(WIDTH); sum/carry valid from then.
REQ-020 sum and carry SHALL hold the last result from DONE through IDLE until the next accepted start's first RUN edge begins overwriting them.
REQ-021 start while RUN SHALL be ignored; operands, counter and result unaffected.
REQ-022 Counter width SHALL be ceil(log2(WIDTH)) bits, no wrap beyond WIDTH-1 within an operation.
REQ-023 Arithmetic SHALL be unsigned modulo 2^WIDTH with carry = bit WIDTH of inA+inB.
REQ-024 Outputs SHALL be driven from registers or decoded state only; no combinational path from start/inA/inB to any output.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE, sum=0, carry=0, done=0, busy=0, ready=1, counter=0, shift regs=0, regardless of state.
REQ-026 rst_n=0 overrides start at the same edge; an operation in progress SHALL be abandoned with no done pulse.
REQ-027 First edge with rst_n=1 SHALL behave as a normal IDLE edge (start accepted if high).

Verification
REQ-028 WIDTH=8, start with 0x5A+0x33 -> busy for 8 cycles, done one cycle after edge E8, sum=0x8D, carry=0.
REQ-029 0xFF+0x01 -> sum=0x00, carry=1; 0xFF+0xFF -> sum=0xFE, carry=1; 0x00+0x00 -> sum=0x00, carry=0.
REQ-030 Start pulsed with new operands at RUN edge 3 of 0x5A+0x33 -> ignored; result still 0x8D/0, done still after E8.
REQ-031 rst_n low at RUN edge 4 -> next cycle IDLE, busy=0, sum=0, carry=0, no done pulse afterwards.
REQ-032 start held high through DONE with 0x01+0x02 then 0x80+0x80 -> done pulses after E8 and E17; results 0x03/0 then 0x00/1.
REQ-033 Exhaustive check for WIDTH=4: all 256 operand pairs, each result compared with inA+inB, done exactly 4 edges after accept.
